// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB requester: address-decoded one-hot selects,
// wait-state handling, misalignment rejection and a stalled-slave watchdog.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              write,
  output logic              enable,
  output logic              sel1,
  output logic              sel2,
  output logic              sel3,
  output logic              sel4,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // The counter only has to reach TIMEOUT-1: the abort fires on the TIMEOUT-th wait cycle.
  localparam int unsigned    CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StErrRsp} state_e;

  state_e            state_q;
  logic              ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q;
  logic              enable_q;
  logic [3:0]        sel_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [CntW-1:0]   cnt_q;

  logic [3:0] sel_dec;
  logic       aligned;
  logic       access_end;

  always_comb begin
    sel_dec = 4'b0000;
    unique case (req_addr[ADDR_W-1 -: 2])
      2'd0: sel_dec = 4'b0001;
      2'd1: sel_dec = 4'b0010;
      2'd2: sel_dec = 4'b0100;
      2'd3: sel_dec = 4'b1000;
    endcase
  end

  assign aligned    = (req_addr[1:0] == 2'b00);
  assign access_end = PREADY || (cnt_q == CntLast);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      enable_q    <= 1'b0;
      sel_q       <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      // Response fields are a single-cycle pulse and read 0 otherwise.
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            ready_q <= 1'b0;
            if (!aligned) begin
              state_q <= StErrRsp;
            end else begin
              state_q <= StSetup;
              addr_q  <= req_addr;
              data_q  <= req_write ? req_wdata : '0;
              write_q <= req_write;
              sel_q   <= sel_dec;
              cnt_q   <= '0;
            end
          end
        end
        StSetup: begin
          state_q  <= StAccess;
          enable_q <= 1'b1;
        end
        StAccess: begin
          if (access_end) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            enable_q    <= 1'b0;
            sel_q       <= 4'b0000;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !PREADY || PSLVERR;
            rsp_rdata_q <= (PREADY && !PSLVERR && !write_q) ? PRDATA : '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StErrRsp: begin
          state_q     <= StIdle;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign write     = write_q;
  assign enable    = enable_q;
  assign sel1      = sel_q[0];
  assign sel2      = sel_q[1];
  assign sel3      = sel_q[2];
  assign sel4      = sel_q[3];

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, reset sequences and random
// transactions checked cycle by cycle against a transaction-level model.
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] addr;
  logic [31:0] data;
  logic        write;
  logic        enable;
  logic        sel1, sel2, sel3, sel4;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int total = 0;
  int bad = 0;

  apb_master_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .addr     (addr),
    .data     (data),
    .write    (write),
    .enable   (enable),
    .sel1     (sel1),
    .sel2     (sel2),
    .sel3     (sel3),
    .sel4     (sel4),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          exp_lat;   // cycles from handshake edge to rsp_valid cycle
    int          exp_sel;   // 0..3, or -1 when no select may ever rise
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [8:0] ctl_now();
    return {sel4, sel3, sel2, sel1, enable, write, req_ready, rsp_valid, rsp_err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome follows directly from the request and slave behaviour.
  task automatic model(input logic wr, input logic [31:0] a, input int waits,
                       input logic [31:0] prd, input logic se, output int lat,
                       output int sel, output logic err, output logic [31:0] rd);
    if (a[1:0] != 2'b00) begin
      lat = 2; sel = -1; err = 1'b1; rd = '0;
    end else begin
      sel = int'(a[31:30]);
      if (waits >= TO) begin
        lat = 2 + TO; err = 1'b1; rd = '0;
      end else begin
        lat = 3 + waits; err = se; rd = (!wr && !se) ? prd : '0;
      end
    end
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] prd, input logic se,
                         input int lat, input int sel, input logic err,
                         input logic [31:0] rd, input string tag);
    logic       aligned;
    logic       in_bus;
    logic [3:0] exp_sel;
    logic [8:0] exp_ctl;
    aligned = (sel >= 0);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge PCLK);
    chk({tag, "/ready_before"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    @(negedge PCLK);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    for (int k = 1; k <= lat; k++) begin
      in_bus  = aligned && (k < lat);
      exp_sel = in_bus ? (4'b0001 << sel) : 4'b0000;
      exp_ctl = {exp_sel, in_bus && (k >= 2), in_bus && wr, k == lat, k == lat,
                 (k == lat) && err};
      chk($sformatf("%s/ctl k=%0d", tag, k), 64'(ctl_now()), 64'(exp_ctl));
      chk($sformatf("%s/rdata k=%0d", tag, k), 64'(rsp_rdata), (k == lat) ? 64'(rd) : 64'd0);
      if (aligned) begin
        chk($sformatf("%s/addr k=%0d", tag, k), 64'(addr), 64'(a));
        chk($sformatf("%s/data k=%0d", tag, k), 64'(data), wr ? 64'(wd) : 64'd0);
      end
      if (aligned && k >= 2 && k < lat) begin
        PREADY  = ((k - 2) >= waits);
        PRDATA  = PREADY ? prd : $urandom;
        PSLVERR = PREADY ? se : 1'($urandom_range(0, 1));
      end else if (k < lat) begin
        // Junk outside ACCESS must be ignored.
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = $urandom;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      if (k < lat) @(negedge PCLK);
    end
  endtask

  initial begin
    int          lat, sel, waits;
    logic        err, wr, se;
    logic [31:0] rd, a, wd, prd;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 3, 0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h8000_0004, 32'h0, 3, 32'h1234_5678, 1'b0, 6, 2, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'hC000_0000, 32'h0, 0, 32'hFFFF_0000, 1'b1, 3, 3, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h4000_0002, 32'h5555_AAAA, 0, 32'h0, 1'b0, 2, -1, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0100, 32'h0, 16, 32'h7777_7777, 1'b0, 18, 0, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h4000_0008, 32'h0, 15, 32'hA5A5_5A5A, 1'b0, 18, 1, 1'b0, 32'hA5A5_5A5A};
    vecs[6] = '{1'b1, 32'h8000_000C, 32'h1111_2222, 2, 32'h9999_9999, 1'b1, 5, 2, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'hC000_0001, 32'h0, 0, 32'h0, 1'b0, 2, -1, 1'b1, 32'h0};

    // Reset state, then ready rises once reset is released.
    repeat (2) @(negedge PCLK);
    chk("rst/ctl", 64'(ctl_now()), 64'd0);
    chk("rst/addr", 64'(addr), 64'd0);
    chk("rst/data", 64'(data), 64'd0);
    chk("rst/rdata", 64'(rsp_rdata), 64'd0);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rst/release_ctl", 64'(ctl_now()), 64'(9'b0000_0_0_1_0_0));

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].prdata,
              vecs[i].slverr, vecs[i].exp_lat, vecs[i].exp_sel, vecs[i].exp_err,
              vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // Asynchronous reset while a read is stalled in ACCESS.
    @(negedge PCLK);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h8000_0000;
    PREADY    = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("midrst/access_ctl", 64'(ctl_now()), 64'(9'b0100_1_0_0_0_0));
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst/ctl", 64'(ctl_now()), 64'd0);
    chk("midrst/addr", 64'(addr), 64'd0);
    chk("midrst/data", 64'(data), 64'd0);
    chk("midrst/rdata", 64'(rsp_rdata), 64'd0);
    @(negedge PCLK);
    #2 PRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk($sformatf("midrst/idle%0d", i), 64'(ctl_now()), 64'(9'b0000_0_0_1_0_0));
    end
    run_txn(1'b1, 32'h4000_0000, 32'h0BAD_F00D, 1, 32'h0, 1'b0, 4, 1, 1'b0, 32'h0,
            "post_rst");

    // Random transactions, back to back, against the transaction model.
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wd  = $urandom;
      prd = $urandom;
      se  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 7) waits = int'($urandom_range(0, 4));
      else waits = TO - 2 + int'($urandom_range(0, 3));
      model(wr, a, waits, prd, se, lat, sel, err, rd);
      run_txn(wr, a, wd, waits, prd, se, lat, sel, err, rd, $sformatf("rnd%0d", n));
    end

    @(negedge PCLK);
    chk("final/idle", 64'(ctl_now()), 64'(9'b0000_0_0_1_0_0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester. Converts a single-outstanding valid/ready request port into APB transfers (IDLE -> SETUP -> ACCESS) on the bus that the APB protocol checker and slaves observe.
- Decodes the address into four one-hot slave selects.
- Inserts wait states on PREADY low and returns read data or error on a one-cycle response pulse.
- Aborts stalled slaves with a timeout watchdog.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (must be >= 1).

Ports:
- PCLK  in  1  bus clock, all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- rsp_err  out  1  PSLVERR, misalignment or timeout.
- addr  out  ADDR_W  APB address.
- data  out  DATA_W  APB write data.
- write  out  1  APB direction.
- enable  out  1  APB enable (ACCESS phase).
- sel1, sel2, sel3, sel4  out  1 each  one-hot slave selects.
- PRDATA  in  DATA_W  read data from selected slave.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error, sampled only with PREADY in ACCESS.

Behaviour:
- Reset (PRESETn low, asynchronous): state IDLE; addr, data, write, enable, sel1..sel4, rsp_valid, rsp_err, rsp_rdata and the timeout counter all 0; req_ready 0 while reset is asserted, 1 in the first cycle after release. Reset mid-transfer drops the transfer and emits no response.
- FSM states: IDLE, SETUP, ACCESS, ERRRSP.
- req_ready = 1 only in IDLE. A handshake is req_valid & req_ready at a rising edge.
- Decode on acceptance: req_addr[ADDR_W-1:ADDR_W-2] = 0/1/2/3 selects sel1/sel2/sel3/sel4. Exactly one select is high in SETUP and ACCESS; all selects are low in IDLE and ERRRSP.
- Alignment check: req_addr[1:0] != 0 -> go to ERRRSP. No select or enable is asserted. Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0, then IDLE.
- IDLE -> SETUP on an aligned handshake:
  - addr, data (= req_wdata on writes, 0 on reads), write and the decoded select are registered.
  - enable = 0 in SETUP.
  - SETUP always lasts exactly one cycle and then goes to ACCESS.
- ACCESS:
  - enable = 1; addr, data, write and the select are held stable.
  - PREADY low: stay in ACCESS and increment the wait counter.
  - PREADY high: the transfer completes at that edge. Next cycle is IDLE with rsp_valid=1, rsp_err=PSLVERR, rsp_rdata = PRDATA (reads with no error) else 0.
- Timeout: when the wait counter reaches TIMEOUT while PREADY is still low, abort to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0. The counter clears on every entry to SETUP.
- On return to IDLE:
  - enable=0 and all selects=0.
  - addr and data hold their last values.
  - write returns to 0.
- Latency: handshake at edge T -> SETUP during cycle T+1 -> ACCESS from T+2 -> rsp_valid in cycle T+3 + N, where N = number of wait states. Minimum issue interval is 3 cycles; a new request may be accepted in the rsp_valid cycle.
- rsp_valid is a single-cycle pulse with no back-pressure; the consumer must sample it.
- rsp_rdata and rsp_err are meaningful only while rsp_valid is high, and read 0 otherwise.

Test Plan:
- Write, zero wait states: req addr=0x0000_0010, wdata=0xDEAD_BEEF, write=1 -> SETUP with sel1=1, enable=0, data=0xDEADBEEF; ACCESS enable=1; PREADY=1 -> rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x8000_0004, PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678 -> sel3 held for 4 ACCESS cycles; rsp_valid at T+6, rsp_rdata=0x12345678, rsp_err=0.
- Slave error: read addr=0xC000_0000 with PREADY=1, PSLVERR=1 -> sel4; rsp_err=1, rsp_rdata=0.
- Misaligned: addr=0x4000_0002 -> no select/enable ever asserted; rsp_valid at T+2 with rsp_err=1.
- Timeout: TIMEOUT=16, PREADY held low -> after 16 ACCESS wait cycles returns to IDLE; rsp_err=1, rsp_rdata=0; req_ready high again.
- Reset mid-ACCESS: PRESETn low during wait states -> all outputs 0 immediately (asynchronous), no rsp_valid. After release, a normal write to 0x4000_0000 completes with sel2.
